// File: rtl/edge_event_unit.sv
// edge_event_unit: per-channel sync, debounce, edge qualify, sticky pending/overflow, irq.
// Ports: clk, nrst, async_in[NCH], mode[2*NCH], clr[NCH] -> level, edge_pulse, pending, overflow, irq.
module edge_event_unit #(
  parameter int NCH         = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 4
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic [NCH-1:0]   async_in,
  input  logic [2*NCH-1:0] mode,
  input  logic [NCH-1:0]   clr,
  output logic [NCH-1:0]   level,
  output logic [NCH-1:0]   edge_pulse,
  output logic [NCH-1:0]   pending,
  output logic [NCH-1:0]   overflow,
  output logic             irq
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic [NCH-1:0] sync_q [SYNC_STAGES];
  logic [NCH-1:0] sync_d [SYNC_STAGES];
  logic [CW-1:0]  cnt_q  [NCH];
  logic [CW-1:0]  cnt_d  [NCH];

  logic [NCH-1:0] level_q, level_d;
  logic [NCH-1:0] pulse_q, pulse_d;
  logic [NCH-1:0] pend_q, pend_d;
  logic [NCH-1:0] ovf_q, ovf_d;
  logic           irq_q, irq_d;

  logic [NCH-1:0] s;
  logic [NCH-1:0] qual;

  always_comb begin
    sync_d[0] = async_in;
    for (int k = 1; k < SYNC_STAGES; k++) begin
      sync_d[k] = sync_q[k-1];
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // A new level is accepted only after it has differed from
  // the current level for DEB_CYCLES consecutive samples.
  always_comb begin
    level_d = level_q;
    qual    = '0;
    for (int i = 0; i < NCH; i++) begin
      cnt_d[i] = '0;
      if (s[i] != level_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          level_d[i] = s[i];
          qual[i]    = s[i] ? mode[2*i] : mode[2*i+1];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // New event beats a coincident clear; overflow needs an
  // event on an already pending channel with no clear.
  always_comb begin
    pulse_d = qual;
    pend_d  = qual | (pend_q & ~clr);
    ovf_d   = (ovf_q | (qual & pend_q)) & ~clr;
    irq_d   = |pend_d;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sync_q  <= '{default: '0};
      cnt_q   <= '{default: '0};
      level_q <= '0;
      pulse_q <= '0;
      pend_q  <= '0;
      ovf_q   <= '0;
      irq_q   <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      irq_q   <= irq_d;
    end
  end

  assign level      = level_q;
  assign edge_pulse = pulse_q;
  assign pending    = pend_q;
  assign overflow   = ovf_q;
  assign irq        = irq_q;

endmodule

// File: tb/tb_edge_event_unit.sv
// tb_edge_event_unit: directed vector table, reset corner case
// and random stimulus against a behavioural event model.
module tb_edge_event_unit;

  localparam int NCH  = 4;
  localparam int SYNC = 2;
  localparam int DEB  = 4;

  logic             clk = 1'b0;
  logic             nrst = 1'b0;
  logic [NCH-1:0]   async_in = '0;
  logic [2*NCH-1:0] mode = '0;
  logic [NCH-1:0]   clr = '0;
  logic [NCH-1:0]   level, edge_pulse, pending, overflow;
  logic             irq;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  edge_event_unit #(
    .NCH(NCH), .SYNC_STAGES(SYNC), .DEB_CYCLES(DEB)
  ) dut (
    .clk(clk), .nrst(nrst), .async_in(async_in),
    .mode(mode), .clr(clr), .level(level),
    .edge_pulse(edge_pulse), .pending(pending),
    .overflow(overflow), .irq(irq)
  );

  task automatic chk(string name, logic [NCH-1:0] act,
                     logic [NCH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic chk1(string name, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t",
               name, act, exp, $time);
    end
  endtask

  // Model: input history queue, run length of disagreement.
  logic [NCH-1:0] m_hist[$];
  int             m_run[NCH];
  logic [NCH-1:0] m_level, m_pulse, m_pend, m_ovf;
  logic           m_irq;

  task automatic model_reset();
    m_hist.delete();
    for (int i = 0; i < NCH; i++) m_run[i] = 0;
    m_level = '0;
    m_pulse = '0;
    m_pend  = '0;
    m_ovf   = '0;
    m_irq   = 1'b0;
  endtask

  task automatic model_edge();
    logic [NCH-1:0] s_pre;
    logic [NCH-1:0] q;
    s_pre = (m_hist.size() >= SYNC) ? m_hist[SYNC-1] : '0;
    m_hist.push_front(async_in);
    if (m_hist.size() > SYNC) void'(m_hist.pop_back());
    q = '0;
    for (int i = 0; i < NCH; i++) begin
      if (s_pre[i] != m_level[i]) begin
        m_run[i]++;
        if (m_run[i] == DEB) begin
          m_level[i] = s_pre[i];
          m_run[i] = 0;
          q[i] = s_pre[i] ? mode[2*i] : mode[2*i+1];
        end
      end else begin
        m_run[i] = 0;
      end
    end
    m_ovf   = (m_ovf | (q & m_pend)) & ~clr;
    m_pend  = q | (m_pend & ~clr);
    m_pulse = q;
    m_irq   = |m_pend;
  endtask

  task automatic model_check();
    chk("m.level", level, m_level);
    chk("m.edge_pulse", edge_pulse, m_pulse);
    chk("m.pending", pending, m_pend);
    chk("m.overflow", overflow, m_ovf);
    chk1("m.irq", irq, m_irq);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    model_check();
  endtask

  task automatic chk_zero(string tag);
    chk({tag, ".level"}, level, '0);
    chk({tag, ".edge_pulse"}, edge_pulse, '0);
    chk({tag, ".pending"}, pending, '0);
    chk({tag, ".overflow"}, overflow, '0);
    chk1({tag, ".irq"}, irq, 1'b0);
  endtask

  task automatic do_reset();
    #2 nrst = 1'b0;
    #1 chk_zero("rst");
    model_reset();
    @(negedge clk);
    nrst = 1'b1;
  endtask

  typedef struct {
    logic [NCH-1:0] ain;
    logic [NCH-1:0] cl;
    int             n;
    logic [NCH-1:0] lv;
    logic [NCH-1:0] pu;
    logic [NCH-1:0] pe;
    logic [NCH-1:0] ov;
    logic           iq;
  } vec_t;

  vec_t tbl[$];

  initial begin
    // ch3 both, ch2 fall, ch1 both, ch0 rise
    mode = 8'hED;
    tbl.push_back('{4'b0001, 4'b0000,  5, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0});
    tbl.push_back('{4'b0001, 4'b0000,  1, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 1'b1});
    tbl.push_back('{4'b0001, 4'b0000,  1, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 1'b1});
    tbl.push_back('{4'b0011, 4'b0000,  3, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 1'b1});
    tbl.push_back('{4'b0001, 4'b0000,  8, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 1'b1});
    tbl.push_back('{4'b0101, 4'b0000, 10, 4'b0101, 4'b0000, 4'b0001, 4'b0000, 1'b1});
    tbl.push_back('{4'b0001, 4'b0000,  5, 4'b0101, 4'b0000, 4'b0001, 4'b0000, 1'b1});
    tbl.push_back('{4'b0001, 4'b0000,  1, 4'b0001, 4'b0100, 4'b0101, 4'b0000, 1'b1});
    tbl.push_back('{4'b0001, 4'b0000,  1, 4'b0001, 4'b0000, 4'b0101, 4'b0000, 1'b1});
    tbl.push_back('{4'b1001, 4'b0000,  6, 4'b1001, 4'b1000, 4'b1101, 4'b0000, 1'b1});
    tbl.push_back('{4'b0001, 4'b0000,  6, 4'b0001, 4'b1000, 4'b1101, 4'b1000, 1'b1});
    tbl.push_back('{4'b0001, 4'b1000,  1, 4'b0001, 4'b0000, 4'b0101, 4'b0000, 1'b1});
    tbl.push_back('{4'b0001, 4'b0101,  1, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0});
    tbl.push_back('{4'b0000, 4'b0000,  6, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0});
    tbl.push_back('{4'b0001, 4'b0000,  6, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 1'b1});
    tbl.push_back('{4'b0000, 4'b0000,  6, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 1'b1});
    tbl.push_back('{4'b0001, 4'b0000,  5, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 1'b1});
    tbl.push_back('{4'b0001, 4'b0001,  1, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 1'b1});
    tbl.push_back('{4'b0001, 4'b0000,  1, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 1'b1});

    model_reset();
    @(negedge clk);
    chk_zero("init");
    nrst = 1'b1;

    foreach (tbl[k]) begin
      async_in = tbl[k].ain;
      clr      = tbl[k].cl;
      repeat (tbl[k].n) step();
      clr = '0;
      chk($sformatf("vec%0d.level", k), level, tbl[k].lv);
      chk($sformatf("vec%0d.pulse", k), edge_pulse, tbl[k].pu);
      chk($sformatf("vec%0d.pending", k), pending, tbl[k].pe);
      chk($sformatf("vec%0d.overflow", k), overflow, tbl[k].ov);
      chk1($sformatf("vec%0d.irq", k), irq, tbl[k].iq);
    end

    // Reset mid-debounce on ch1 with ch0 pending, inputs held high.
    async_in = 4'b0011;
    repeat (4) step();
    do_reset();
    repeat (5) step();
    chk("rel5.level", level, 4'b0000);
    chk("rel5.pending", pending, 4'b0000);
    step();
    chk("rel6.level", level, 4'b0011);
    chk("rel6.pulse", edge_pulse, 4'b0011);
    chk("rel6.pending", pending, 4'b0011);
    chk1("rel6.irq", irq, 1'b1);
    step();
    chk("rel7.pulse", edge_pulse, 4'b0000);

    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NCH; i++) begin
        if ($urandom_range(5) == 0) async_in[i] = ~async_in[i];
      end
      clr = '0;
      for (int i = 0; i < NCH; i++) begin
        if ($urandom_range(7) == 0) clr[i] = 1'b1;
      end
      if ($urandom_range(19) == 0) mode = 8'($urandom);
      if ($urandom_range(299) == 0) do_reset();
      else step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
